// File: rtl/bcp_clause_scheduler.sv
// Walks the clause memory for one BCP pass, forwarding implied literals through a
// single-entry slot and stopping early when a clause is found in conflict.
module bcp_clause_scheduler #(
  parameter int unsigned NUM_CLAUSE     = 256,
  parameter int unsigned CLAUSE_INDEX   = 8 - 1,
  parameter int unsigned NUM_VARIABLE   = 128,
  parameter int unsigned VARIABLE_INDEX = 7 - 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CLAUSE_INDEX:0]   last_clause,
  output logic                    mem_rd_en,
  output logic [CLAUSE_INDEX:0]   mem_rd_addr,
  input  logic                    eval_unit,
  input  logic                    eval_conflict,
  input  logic [VARIABLE_INDEX:0] eval_var,
  input  logic                    eval_val,
  output logic                    imp_valid,
  input  logic                    imp_ready,
  output logic [VARIABLE_INDEX:0] imp_var,
  output logic                    imp_val,
  output logic                    busy,
  output logic                    done,
  output logic                    conflict,
  output logic [CLAUSE_INDEX:0]   conflict_clause,
  output logic [CLAUSE_INDEX+1:0] unit_count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SCAN  = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CLAUSE_INDEX:0] MaxClause = (CLAUSE_INDEX + 1)'(NUM_CLAUSE - 1);

  logic [2:0]              state_q, state_d;
  logic [CLAUSE_INDEX:0]   last_q, last_d;
  logic [CLAUSE_INDEX:0]   next_addr_q, next_addr_d;
  logic                    issued_all_q, issued_all_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [CLAUSE_INDEX:0]   pend_addr_q, pend_addr_d;
  logic                    imp_valid_q, imp_valid_d;
  logic [VARIABLE_INDEX:0] imp_var_q, imp_var_d;
  logic                    imp_val_q, imp_val_d;
  logic                    conflict_q, conflict_d;
  logic [CLAUSE_INDEX:0]   conflict_clause_q, conflict_clause_d;
  logic [CLAUSE_INDEX+1:0] unit_count_q, unit_count_d;

  logic issue, accept, slot_free, unit_hit;

  assign issue     = (state_q == SCAN) && !issued_all_q;
  assign accept    = imp_valid_q && imp_ready;
  assign slot_free = !imp_valid_q || imp_ready;
  assign unit_hit  = pend_valid_q && eval_unit && (32'(eval_var) < NUM_VARIABLE);

  always_comb begin
    state_d           = state_q;
    last_d            = last_q;
    next_addr_d       = next_addr_q;
    issued_all_d      = issued_all_q;
    pend_valid_d      = pend_valid_q;
    pend_addr_d       = pend_addr_q;
    imp_valid_d       = imp_valid_q;
    imp_var_d         = imp_var_q;
    imp_val_d         = imp_val_q;
    conflict_d        = conflict_q;
    conflict_clause_d = conflict_clause_q;
    unit_count_d      = unit_count_q;

    if (accept) begin
      imp_valid_d  = 1'b0;
      unit_count_d = unit_count_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          last_d            = (32'(last_clause) > NUM_CLAUSE - 1) ? MaxClause : last_clause;
          conflict_d        = 1'b0;
          conflict_clause_d = '0;
          unit_count_d      = '0;
          next_addr_d       = '0;
          issued_all_d      = 1'b0;
          pend_valid_d      = 1'b0;
          state_d           = SCAN;
        end
      end
      SCAN: begin
        if (pend_valid_q && eval_conflict) begin
          conflict_d        = 1'b1;
          conflict_clause_d = pend_addr_q;
          pend_valid_d      = 1'b0;
          state_d           = DRAIN;
        end else if (unit_hit && !slot_free) begin
          // Slot blocked: drop this result and re-read the clause once the slot drains.
          next_addr_d  = pend_addr_q;
          issued_all_d = 1'b0;
          pend_valid_d = 1'b0;
          state_d      = HOLD;
        end else begin
          if (unit_hit) begin
            imp_valid_d = 1'b1;
            imp_var_d   = eval_var;
            imp_val_d   = eval_val;
          end
          pend_valid_d = issue;
          if (issue) begin
            pend_addr_d = next_addr_q;
            next_addr_d = next_addr_q + 1'b1;
            if (next_addr_q == last_q) issued_all_d = 1'b1;
          end else begin
            state_d = imp_valid_d ? DRAIN : DONE;
          end
        end
      end
      HOLD:    if (!imp_valid_q) state_d = SCAN;
      DRAIN:   if (!imp_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d           = IDLE;
      imp_valid_d       = 1'b0;
      pend_valid_d      = 1'b0;
      conflict_d        = conflict_q;
      conflict_clause_d = conflict_clause_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      last_q            <= '0;
      next_addr_q       <= '0;
      issued_all_q      <= 1'b0;
      pend_valid_q      <= 1'b0;
      pend_addr_q       <= '0;
      imp_valid_q       <= 1'b0;
      imp_var_q         <= '0;
      imp_val_q         <= 1'b0;
      conflict_q        <= 1'b0;
      conflict_clause_q <= '0;
      unit_count_q      <= '0;
    end else begin
      state_q           <= state_d;
      last_q            <= last_d;
      next_addr_q       <= next_addr_d;
      issued_all_q      <= issued_all_d;
      pend_valid_q      <= pend_valid_d;
      pend_addr_q       <= pend_addr_d;
      imp_valid_q       <= imp_valid_d;
      imp_var_q         <= imp_var_d;
      imp_val_q         <= imp_val_d;
      conflict_q        <= conflict_d;
      conflict_clause_q <= conflict_clause_d;
      unit_count_q      <= unit_count_d;
    end
  end

  assign mem_rd_en       = issue;
  assign mem_rd_addr     = issue ? next_addr_q : '0;
  assign imp_valid       = imp_valid_q;
  assign imp_var         = imp_var_q;
  assign imp_val         = imp_val_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign conflict        = conflict_q;
  assign conflict_clause = conflict_clause_q;
  assign unit_count      = unit_count_q;

endmodule

// File: tb/tb_bcp_clause_scheduler.sv
// Table-driven bench for bcp_clause_scheduler with a clause-table evaluator model and an
// implication scoreboard, plus hand-written abort and asynchronous-reset sequences.
module tb_bcp_clause_scheduler;

  logic       clock = 1'b0;
  logic       reset, start, abort, imp_ready;
  logic [7:0] last_clause;
  logic       mem_rd_en, eval_unit, eval_conflict, eval_val;
  logic [7:0] mem_rd_addr, conflict_clause;
  logic [6:0] eval_var, imp_var;
  logic       imp_valid, imp_val, busy, done, conflict;
  logic [8:0] unit_count;

  bcp_clause_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .last_clause(last_clause),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .eval_unit(eval_unit),
    .eval_conflict(eval_conflict), .eval_var(eval_var), .eval_val(eval_val),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_var(imp_var), .imp_val(imp_val),
    .busy(busy), .done(done), .conflict(conflict), .conflict_clause(conflict_clause),
    .unit_count(unit_count)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;

  typedef struct {
    int           last;
    logic [255:0] umask;
    int           conf;
    int           rmode;     // 0 ready high, 1 low for rlow cycles, 2 random, 3 manual
    int           rlow;
    int           exp_busy;  // 0 = not checked
    int           exp_reads; // 0 = not checked
  } vec_t;

  // Evaluator model: result of the clause read last cycle.
  logic [255:0] umask = '0;
  int           conf_idx = -1;
  logic         rd_q;
  logic [7:0]   addr_q;

  function automatic logic [6:0] var_of(input logic [7:0] a);
    return 7'(int'(a) * 3 - 1);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      rd_q   <= mem_rd_en;
      addr_q <= mem_rd_addr;
    end
  end

  assign eval_unit     = rd_q && umask[addr_q];
  assign eval_conflict = rd_q && (conf_idx >= 0) && (int'(addr_q) == conf_idx);
  assign eval_var      = var_of(addr_q);
  assign eval_val      = ~addr_q[0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Downstream ready driver.
  int rmode = 3, rlow = 0, pcyc = 0;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      pcyc++;
      case (rmode)
        0:       imp_ready = 1'b1;
        1:       imp_ready = 1'(pcyc > rlow);
        2:       imp_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  // Monitor and scoreboard.
  logic [7:0] sb[$];
  logic [7:0] exp_imp;
  bit mon_en = 0;
  int rd_count, max_rd, busy_cyc, done_cnt;

  always @(negedge clock) begin
    if (!reset && mon_en) begin
      if (mem_rd_en) begin
        rd_count++;
        if (int'(mem_rd_addr) > max_rd) max_rd = int'(mem_rd_addr);
      end
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (imp_valid && imp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_imp", {imp_var, imp_val}, 64'hFFFF);
        end else begin
          exp_imp = sb.pop_front();
          chk("imp_literal", {imp_var, imp_val}, exp_imp);
        end
      end
    end
  end

  task automatic run_pass(input vec_t v, input string tag);
    bit has_conf;
    int n_units, exp_max;
    has_conf = (v.conf >= 0) && (v.conf <= v.last);
    umask    = v.umask;
    conf_idx = v.conf;
    rmode    = v.rmode;
    rlow     = v.rlow;
    sb.delete();
    for (int c = 0; c <= v.last; c++) begin
      if (has_conf && c == v.conf) break;
      if (v.umask[c]) sb.push_back({var_of(8'(c)), ~c[0]});
    end
    n_units  = sb.size();
    exp_max  = has_conf ? ((v.conf < v.last) ? v.conf + 1 : v.last) : v.last;
    rd_count = 0;
    max_rd   = -1;
    busy_cyc = 0;
    done_cnt = 0;
    @(posedge clock);
    #1;
    last_clause = 8'(v.last);
    start  = 1'b1;
    pcyc   = 0;
    mon_en = 1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    mon_en = 0;
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_imp_valid_end"}, imp_valid, 0);
    chk({tag, "_unit_count"}, unit_count, n_units);
    chk({tag, "_conflict"}, conflict, has_conf);
    chk({tag, "_conflict_clause"}, conflict_clause, has_conf ? v.conf : 0);
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_max_rd"}, max_rd, exp_max);
    if (v.exp_reads != 0) chk({tag, "_reads"}, rd_count, v.exp_reads);
    if (v.exp_busy != 0) chk({tag, "_busy_cycles"}, busy_cyc, v.exp_busy);
  endtask

  vec_t vecs[9];
  logic [255:0] one = 256'd1;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; last_clause = '0; imp_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outputs", {mem_rd_en, mem_rd_addr, imp_valid, imp_var, imp_val, busy, done,
                          conflict, conflict_clause, unit_count}, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    vecs[0] = '{last: 3, umask: '0, conf: -1, rmode: 0, rlow: 0, exp_busy: 6, exp_reads: 4};
    vecs[1] = '{last: 7, umask: one << 2, conf: -1, rmode: 0, rlow: 0,
                exp_busy: 10, exp_reads: 8};
    vecs[2] = '{last: 7, umask: (one << 1) | (one << 2), conf: -1, rmode: 1, rlow: 6,
                exp_busy: 0, exp_reads: 10};
    vecs[3] = '{last: 9, umask: (one << 1) | (one << 4), conf: 4, rmode: 0, rlow: 0,
                exp_busy: 0, exp_reads: 6};
    vecs[4] = '{last: 0, umask: '0, conf: -1, rmode: 0, rlow: 0, exp_busy: 3, exp_reads: 1};
    vecs[5] = '{last: 255, umask: '0, conf: -1, rmode: 0, rlow: 0,
                exp_busy: 258, exp_reads: 256};
    vecs[6] = '{last: 40, umask: {8{$urandom}}, conf: -1, rmode: 2, rlow: 0,
                exp_busy: 0, exp_reads: 0};
    vecs[7] = '{last: 60, umask: {8{$urandom}}, conf: 50, rmode: 2, rlow: 0,
                exp_busy: 0, exp_reads: 0};
    vecs[8] = '{last: 0, umask: one, conf: -1, rmode: 0, rlow: 0, exp_busy: 5, exp_reads: 1};

    for (int i = 0; i < 9; i++) run_pass(vecs[i], $sformatf("vec%0d", i));

    // Abort while rewound in HOLD.
    umask = (one << 1) | (one << 2);
    conf_idx = -1;
    rmode = 3;
    imp_ready = 1'b0;
    @(posedge clock);
    #1 last_clause = 8'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    begin
      bit seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge clock);
        if (busy && imp_valid && !mem_rd_en) seen = 1;
      end
      chk("abort_hold_reached", seen, 1);
    end
    @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("abort_idle", busy, 0);
    chk("abort_imp_valid", imp_valid, 0);
    chk("abort_no_done", done, 0);
    chk("abort_conflict", conflict, 0);
    run_pass(vecs[1], "after_abort");

    // Asynchronous reset in the middle of a scan.
    umask = 256'h3E;
    rmode = 0;
    @(posedge clock);
    #1 last_clause = 8'd200; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (15) @(negedge clock);
    chk("pre_reset_units", unit_count, 5);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_outputs", {mem_rd_en, mem_rd_addr, imp_valid, imp_var, imp_val, done,
                                conflict, conflict_clause, unit_count}, 0);
    chk("async_reset_busy", busy, 0);
    #20;
    @(posedge clock);
    #1 reset = 1'b0;
    run_pass(vecs[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
